core_inst_seq: RTL



---
 rtl/core_inst_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer that drives the core inst bus for one full conv layer.
// Optional OF_WAIT timeout with sticky err: define SEQ_OFIFO_TIMEOUT_EN.
module core_inst_seq #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_ONIJ = 16,
  parameter int ACT_BASE = 0,
  parameter int W_BASE   = 1024,
  parameter int P_BASE   = 0,
  parameter int GAP      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  input  logic [10:0] acc_addr,
  output logic [34:0] inst,
  output logic        core_clr,
  output logic [7:0]  acc_idx,
  output logic        sfp_valid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij,
  output logic        err
);

  localparam logic [34:0] INST_IDLE = 35'h1800C0000;
  localparam int          EXEC_LEN  = LEN_NIJ + ROW + COL;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC, S_OF_WAIT, S_OF_RD, S_ACC, S_DONE
  } state_t;

  state_t      r_state;
  logic [6:0]  r_t;
  logic [4:0]  r_o;
  logic [3:0]  r_kij;
  logic [7:0]  r_acc_idx;
  logic [34:0] r_inst;
  logic        r_core_clr;
  logic        r_sfp_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [34:0] w_inst;
  logic        w_last;
  logic        w_pwr;
  logic        w_prd;

  // Instruction word for the current state/cycle, registered onto inst one cycle later
  always_comb begin
    w_inst = INST_IDLE;
    w_last = 1'b0;
    w_pwr  = 1'b0;
    w_prd  = 1'b0;
    case (r_state)
      S_W_L0: begin
        w_inst[19]   = (r_t >= 7'(COL));
        w_inst[17:7] = (r_t < 7'(COL)) ? 11'(W_BASE + int'(r_kij) * COL + int'(r_t)) : 11'd0;
        w_inst[2]    = (r_t != 7'd0);
        w_last       = (r_t == 7'(COL));
      end
      S_W_LOAD: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
        w_last    = (r_t == 7'(COL - 1));
      end
      S_GAP: begin
        w_last = (r_t == 7'(GAP - 1));
      end
      S_A_L0: begin
        w_inst[19]   = (r_t >= 7'(LEN_NIJ));
        w_inst[17:7] = (r_t < 7'(LEN_NIJ)) ? 11'(ACT_BASE + int'(r_t)) : 11'd0;
        w_inst[2]    = (r_t != 7'd0);
        w_last       = (r_t == 7'(LEN_NIJ));
      end
      S_EXEC: begin
        w_inst[1] = (r_t < 7'(LEN_NIJ));
        w_inst[3] = (r_t < 7'(LEN_NIJ));
        w_last    = (r_t == 7'(EXEC_LEN - 1));
      end
      S_OF_WAIT: begin
        w_last = ofifo_valid;
      end
      S_OF_RD: begin
        // pmem write trails the OFIFO read by one cycle
        w_pwr         = (r_t != 7'd0);
        w_inst[6]     = (r_t < 7'(LEN_NIJ));
        w_inst[32]    = ~w_pwr;
        w_inst[31]    = ~w_pwr;
        w_inst[30:20] = w_pwr ? 11'(P_BASE + int'(r_kij) * LEN_NIJ + int'(r_t) - 1) : 11'd0;
        w_last        = (r_t == 7'(LEN_NIJ));
      end
      S_ACC: begin
        w_prd         = (r_t >= 7'd1) && (r_t <= 7'(LEN_KIJ));
        w_inst[33]    = (r_t >= 7'd2) && (r_t <= 7'(LEN_KIJ + 1));
        w_inst[32]    = ~w_prd;
        w_inst[30:20] = w_prd ? acc_addr : 11'd0;
        w_last        = (r_t == 7'(LEN_KIJ + 2));
      end
      default: begin
        w_last = 1'b0;
      end
    endcase
  end

  // Sequencer FSM; acc_idx runs one cycle ahead of inst so acc_addr is ready when inst registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_t         <= 7'd0;
      r_o         <= 5'd0;
      r_kij       <= 4'd0;
      r_acc_idx   <= 8'd0;
      r_inst      <= INST_IDLE;
      r_core_clr  <= 1'b0;
      r_sfp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_inst      <= w_inst;
      r_core_clr  <= (r_state == S_ACC) && (r_t == 7'd0);
      r_sfp_valid <= (r_state == S_ACC) && (r_t == 7'(LEN_KIJ + 2));
      r_done      <= (r_state == S_DONE);
      r_t         <= w_last ? 7'd0 : r_t + 7'd1;
      case (r_state)
        S_IDLE: begin
          r_t <= 7'd0;
          if (start) begin
            r_state   <= S_W_L0;
            r_kij     <= 4'd0;
            r_acc_idx <= 8'd0;
            r_busy    <= 1'b1;
          end
        end
        S_W_L0:   if (w_last) r_state <= S_W_LOAD;
        S_W_LOAD: if (w_last) r_state <= S_GAP;
        S_GAP:    if (w_last) r_state <= S_A_L0;
        S_A_L0:   if (w_last) r_state <= S_EXEC;
        S_EXEC:   if (w_last) r_state <= S_OF_WAIT;
        S_OF_WAIT: begin
`ifdef SEQ_OFIFO_TIMEOUT_EN
          if (ofifo_valid) begin
            r_state <= S_OF_RD;
          end else if (r_t == 7'd63) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
`else
          if (ofifo_valid) r_state <= S_OF_RD;
          else r_t <= 7'd0;
`endif
        end
        S_OF_RD: begin
          if (w_last) begin
            if (r_kij < 4'(LEN_KIJ - 1)) begin
              r_kij   <= r_kij + 4'd1;
              r_state <= S_W_L0;
            end else begin
              r_o       <= 5'd0;
              r_acc_idx <= 8'd0;
              r_state   <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (w_prd) r_acc_idx <= r_acc_idx + 8'd1;
          if (w_last) begin
            if (r_o == 5'(LEN_ONIJ - 1)) r_state <= S_DONE;
            else r_o <= r_o + 5'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst      = r_inst;
  assign core_clr  = r_core_clr;
  assign acc_idx   = r_acc_idx;
  assign sfp_valid = r_sfp_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign kij       = r_kij;
  assign err       = r_err;

endmodule
